note_tuner_arbiter: RTL

Shares one note_tuner instance between NUM_REQ frequency-measurement requesters.
- Each requester uses a valid/ready handshake; grants are round-robin.
- The block range-checks each frequency, drives the tuner's note input and holds it stable for the tuner's latency, then captures the tuner result.
- The result is returned with a one-hot response pulse that identifies the requester.
- Sits between the frequency counters and the display/LED logic.

---
 rtl/tuner_pkg.sv | 16 +
 rtl/rr_arbiter.sv | 34 +++
 rtl/note_tuner_arbiter.sv | 128 ++++++++++++
 3 files changed

// File: rtl/tuner_pkg.sv
// Shared widths, default frequency window and FSM encoding for the note tuner arbiter.
package tuner_pkg;

  localparam int unsigned FREQ_W       = 19;
  localparam int unsigned NOTE_W       = 4;
  localparam int unsigned FREQ_SCALE   = 1000;
  localparam int unsigned DEF_MIN_FREQ = 50_000;
  localparam int unsigned DEF_MAX_FREQ = 466_000;

  typedef enum logic [1:0] {
    IDLE,
    WAIT,
    RESP
  } state_t;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin grant: first set request at or above rr_ptr, wrapping.
module rr_arbiter #(
  parameter  int unsigned NUM_REQ = 2,
  localparam int unsigned IDX_W   = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   rr_ptr,
  output logic [NUM_REQ-1:0] grant,
  output logic [IDX_W-1:0]   grant_idx,
  output logic               any_req
);

  always_comb begin
    logic [IDX_W:0]   sum;
    logic [IDX_W-1:0] idx;
    grant     = '0;
    grant_idx = '0;
    any_req   = 1'b0;
    sum       = '0;
    idx       = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      // rr_ptr < NUM_REQ, so a single conditional subtract implements the wrap
      sum = {1'b0, rr_ptr} + (IDX_W+1)'(k);
      if (sum >= (IDX_W+1)'(NUM_REQ)) sum = sum - (IDX_W+1)'(NUM_REQ);
      idx = sum[IDX_W-1:0];
      if (!any_req && req[idx]) begin
        any_req    = 1'b1;
        grant[idx] = 1'b1;
        grant_idx  = idx;
      end
    end
  end

endmodule

// File: rtl/note_tuner_arbiter.sv
// Shares one note_tuner among NUM_REQ requesters: round-robin accept, range check,
// hold the tuner input for its latency, then return a registered one-hot response.
module note_tuner_arbiter
  import tuner_pkg::*;
#(
  parameter int unsigned NUM_REQ   = 2,
  parameter int unsigned FREQ_W    = tuner_pkg::FREQ_W,
  parameter int unsigned TUNER_LAT = 2,
  parameter int unsigned MIN_FREQ  = tuner_pkg::DEF_MIN_FREQ,
  parameter int unsigned MAX_FREQ  = tuner_pkg::DEF_MAX_FREQ
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ*FREQ_W-1:0] req_freq,
  output logic [FREQ_W-1:0]         tuner_note,
  input  logic [FREQ_W-1:0]         tuner_closest_freq,
  input  logic [NOTE_W-1:0]         tuner_closest_note,
  input  logic                      tuner_flat,
  input  logic                      tuner_sharp,
  input  logic                      tuner_in_tune,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [FREQ_W-1:0]         rsp_freq,
  output logic [NOTE_W-1:0]         rsp_note,
  output logic                      rsp_flat,
  output logic                      rsp_sharp,
  output logic                      rsp_in_tune,
  output logic                      rsp_err,
  output logic                      busy
);

  localparam int unsigned IDX_W = $clog2(NUM_REQ);
  localparam int unsigned CNT_W = $clog2(TUNER_LAT + 1);

  state_t             state, state_next;
  logic [IDX_W-1:0]   rr_ptr;
  logic [IDX_W-1:0]   g;
  logic [CNT_W-1:0]   cnt;
  logic [NUM_REQ-1:0] grant;
  logic [IDX_W-1:0]   grant_idx;
  logic               any_req;
  logic [FREQ_W-1:0]  sel_freq;
  logic               in_range;
  logic               accept;
  logic               wait_done;

  rr_arbiter #(.NUM_REQ(NUM_REQ)) u_rr_arbiter (
    .req       (req_valid),
    .rr_ptr    (rr_ptr),
    .grant     (grant),
    .grant_idx (grant_idx),
    .any_req   (any_req)
  );

  always_comb begin
    sel_freq = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (grant[i]) sel_freq = req_freq[i*FREQ_W +: FREQ_W];
    end
  end

  assign in_range  = (32'(sel_freq) >= MIN_FREQ) && (32'(sel_freq) <= MAX_FREQ);
  assign accept    = (state == IDLE) && any_req;
  assign wait_done = (state == WAIT) && (cnt == CNT_W'(1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (accept) state_next = in_range ? WAIT : RESP;
      WAIT:    if (wait_done) state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    req_ready = (state == IDLE) ? grant : '0;
    busy      = (state != IDLE);
    rsp_valid = '0;
    if (state == RESP) rsp_valid[g] = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr      <= '0;
      g           <= '0;
      cnt         <= '0;
      tuner_note  <= '0;
      rsp_freq    <= '0;
      rsp_note    <= '0;
      rsp_flat    <= 1'b0;
      rsp_sharp   <= 1'b0;
      rsp_in_tune <= 1'b0;
      rsp_err     <= 1'b0;
    end else if (accept) begin
      g      <= grant_idx;
      rr_ptr <= (grant_idx == IDX_W'(NUM_REQ - 1)) ? '0 : grant_idx + 1'b1;
      if (in_range) begin
        tuner_note <= sel_freq;
        cnt        <= CNT_W'(TUNER_LAT);
      end else begin
        rsp_err     <= 1'b1;
        rsp_freq    <= '0;
        rsp_note    <= '0;
        rsp_flat    <= 1'b0;
        rsp_sharp   <= 1'b0;
        rsp_in_tune <= 1'b0;
      end
    end else if (state == WAIT) begin
      cnt <= cnt - 1'b1;
      if (wait_done) begin
        rsp_err     <= 1'b0;
        rsp_freq    <= tuner_closest_freq;
        rsp_note    <= tuner_closest_note;
        rsp_flat    <= tuner_flat;
        rsp_sharp   <= tuner_sharp;
        rsp_in_tune <= tuner_in_tune;
      end
    end
  end

endmodule
